ram_fifo_ctrl: RTL
==================

Name: ram_fifo_ctrl

Overview:
- FIFO controller sitting directly upstream of the single-port synchronous ram block; it generates that block's we/re/addr/in and consumes its out.
- Presents a valid/ready write port and a valid/ready read port with a one-word output holding register, turning the ram into a 2^ADDR_WIDTH-entry FIFO.
- One ram operation per cycle; read fetches and writes are arbitrated by a small FSM.

Parameters:
- DATA_WIDTH, 7, word width; matches ram data_width.
- ADDR_WIDTH, 5, ram address width; DEPTH = 2^ADDR_WIDTH = 32.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  controller accepts the word this cycle.
- wr_data  in  DATA_WIDTH  write word.
- rd_valid  out  1  rd_data holds a valid word.
- rd_ready  in  1  consumer takes the word.
- rd_data  out  DATA_WIDTH  output holding register.
- level  out  ADDR_WIDTH+1  words stored in ram, excluding the holding register.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0 and rd_valid == 0.
- ram_we  out  1  to ram we.
- ram_re  out  1  to ram re.
- ram_addr  out  ADDR_WIDTH  to ram addr.
- ram_in  out  DATA_WIDTH  to ram in.
- ram_out  in  DATA_WIDTH  from ram out; valid on the clock edge after ram_re is sampled high.

Behaviour:
- Reset (rst=1, async): wr_ptr=0, rd_ptr=0, level=0, rd_valid=0, rd_data=0, state=IDLE. ram_we, ram_re and ram_addr are 0. Outputs: full=0, empty=1. Any in-flight fetch is discarded.
- FSM states: IDLE, FETCH, CAPTURE.
- IDLE -> FETCH when level != 0 and (rd_valid == 0 or rd_valid && rd_ready this cycle). Otherwise stay in IDLE.
- FETCH (1 cycle):
  - ram_re=1, ram_addr=rd_ptr.
  - At the edge: rd_ptr += 1 (mod DEPTH), level -= 1.
  - Always -> CAPTURE.
- CAPTURE (1 cycle):
  - At the edge: rd_data <= ram_out, rd_valid <= 1.
  - -> IDLE.
- Write acceptance:
  - wr_ready = !full && state != FETCH (combinational).
  - On wr_valid && wr_ready: ram_we=1, ram_addr=wr_ptr, ram_in=wr_data. At the edge: wr_ptr += 1 (mod DEPTH), level += 1.
  - Writes are legal in IDLE and CAPTURE.
  - ram_out is unaffected by writes.
- Address mux: in FETCH, rd_ptr. Otherwise wr_ptr when ram_we=1, else 0.
- Read handshake:
  - rd_valid && rd_ready clears rd_valid at the edge, unless CAPTURE reloads it in the same cycle.
  - rd_data holds its value while rd_valid=1 and rd_ready=0.
- Simultaneous write and fetch entry in IDLE:
  - The write proceeds this cycle; the FETCH is taken next cycle.
  - level changes by +1 for the write and -1 for the fetch, each at its own edge.
- Pointers wrap 31 -> 0 with no flag. level never exceeds DEPTH and never underflows.
- wr_valid while full: the word is held off (wr_ready=0), not dropped.
- Steady-state throughput: one read word per 3 cycles, one write per cycle when no fetch is pending.

Optional Feature:
- Macro RAMCTL_WATERMARK_EN.
- Defined:
  - Adds parameter AF_LEVEL, default DEPTH-4, and outputs almost_full and almost_empty (1 bit each, registered).
  - almost_full = level >= AF_LEVEL.
  - almost_empty = level <= 1.
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: the parameter and both ports are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 3 cycles with random inputs -> rd_valid=0, rd_data=0, level=0, empty=1, full=0, wr_ready=1, ram_we=ram_re=0.
- Write 0..4 at addr 0..4, rd_ready=0:
  - Expect ram_we pulses with ram_addr 0,1,2,3,4.
  - Then one FETCH of addr 0; rd_valid=1, rd_data=0, level=4.
- Fill, rd_ready=0, 33 writes -> level=32, full=1, wr_ready=0. A 34th wr_valid is stalled; no ram_we is issued.
- Drain with rd_ready=1 -> rd_data sequence 0..32 in order, one word per 3 cycles; finally empty=1, level=0.
- Wrap: stream 40 words with wr_valid and rd_ready both 1 -> output order equals input order; ram_addr wraps 31->0 for both pointers.
- Async reset mid-FETCH (ram_re=1), asserted between edges -> level=0, rd_valid=0, state=IDLE immediately. The next capture edge does not set rd_valid.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//
// FIFO controller placed in front of a single-port synchronous RAM. It owns
// the RAM's we/re/addr/in pins and turns the array into a 2^ADDR_WIDTH entry
// FIFO. The write side and the read side each have a valid/ready handshake.
// The read side has a one-word holding register (rd_data). The RAM does one
// operation per cycle. A three-state FSM (IDLE -> FETCH -> CAPTURE) moves
// words from the RAM into the holding register. Writes are accepted in any
// state except FETCH.
//
// Optional feature: define RAMCTL_WATERMARK_EN to add parameter AF_LEVEL and
// the registered outputs almost_full / almost_empty.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   wr_valid/ready  write handshake, wr_data is the word to store
//   rd_valid/ready  read handshake, rd_data is the holding register
//   level           words held in RAM (the holding register is not counted)
//   full, empty     level == DEPTH / nothing stored anywhere
//   ram_we/re/addr/in, ram_out   connection to the RAM block
//   almost_full/almost_empty     watermark flags (RAMCTL_WATERMARK_EN only)
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 7,
    parameter int ADDR_WIDTH = 5
`ifdef RAMCTL_WATERMARK_EN
    , parameter int AF_LEVEL = (1 << ADDR_WIDTH) - 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_in,
    input  logic [DATA_WIDTH-1:0] ram_out
`ifdef RAMCTL_WATERMARK_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     level_q, level_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    wr_fire;

    assign full     = (level_q == LVL_FULL);
    assign empty    = (level_q == '0) && !rd_valid_q;
    // The RAM port belongs to the read fetch during FETCH, so writes wait.
    assign wr_ready = !full && (state_q != FETCH);
    // The rst term keeps the RAM untouched while reset is held, even if the
    // producer is presenting data.
    assign wr_fire  = wr_valid && wr_ready && !rst;

    assign ram_we   = wr_fire;
    assign ram_re   = (state_q == FETCH);
    assign ram_addr = ram_re  ? rd_ptr_q :
                      wr_fire ? wr_ptr_q : '0;
    assign ram_in   = wr_fire ? wr_data : '0;

    assign level    = level_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        // Writes never coincide with FETCH, so the two level updates below
        // are mutually exclusive.
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            level_d  = level_q + LVL_ONE;
        end

        case (state_q)
            IDLE: begin
                // Start a fetch when the holding register is free now or
                // is being emptied on this edge.
                if ((level_q != '0) && (!rd_valid_q || rd_ready)) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                level_d  = level_q - LVL_ONE;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                // ram_out holds the word addressed during FETCH.
                rd_data_d  = ram_out;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef RAMCTL_WATERMARK_EN
    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH + 1)'(AF_LEVEL);

    logic almost_full_q, almost_empty_q;

    // Computed from level_d, so the flags line up with level after each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (level_d >= AF_LVL);
            almost_empty_q <= (level_d <= LVL_ONE);
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule
